// File: rtl/patgen_pkg.sv
// Shared definitions for shift_pattern_gen: mode encodings, FSM states,
// default shadow values and small mode-decoding helpers.
package patgen_pkg;

   localparam logic [1:0] MODE_STAT     = 2'b00;
   localparam logic [1:0] MODE_DYN      = 2'b01;
   localparam logic [1:0] MODE_STAT_DYN = 2'b10;
   localparam logic [1:0] MODE_DYN_STAT = 2'b11;

   localparam logic [87:0] STAT_INIT_DEF = 88'h123456789ABCDEF1234567;
   localparam logic [15:0] DYN_INIT_DEF  = 16'hABCD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEG0 = 2'd1,
      SEG1 = 2'd2
   } state_t;

   function automatic logic stat_first(input logic [1:0] mode);
      return (mode == MODE_STAT) || (mode == MODE_STAT_DYN);
   endfunction

   function automatic logic two_seg(input logic [1:0] mode);
      return (mode == MODE_STAT_DYN) || (mode == MODE_DYN_STAT);
   endfunction

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load, MSB-first shift register with zero fill. Exposes the
// current MSB and the bit that becomes MSB after the next shift.
module pattern_shifter #(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb,
   output logic         nxt
);

   logic [W-1:0] q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         q <= '0;
      else if (load)
         q <= din;
      else if (shift)
         q <= {q[W-2:0], 1'b0};
   end

   assign msb = q[W-1];
   assign nxt = q[W-2];

endmodule

// File: rtl/shift_pattern_gen.sv
// Serialises static/dynamic pattern words MSB-first with START/BUSY/DONE
// handshake and ABORT. Optional continuous looping via `PATGEN_LOOP_EN.
module shift_pattern_gen
   import patgen_pkg::*;
#(
   parameter int unsigned          STAT_W    = 88,
   parameter int unsigned          DYN_W     = 16,
   parameter logic [STAT_W-1:0]    STAT_INIT = STAT_W'(STAT_INIT_DEF),
   parameter logic [DYN_W-1:0]     DYN_INIT  = DYN_W'(DYN_INIT_DEF)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              LOAD,
   input  logic [STAT_W-1:0] STAT_IN,
   input  logic [DYN_W-1:0]  DYN_IN,
   input  logic [1:0]        MODE,
   input  logic              START,
   input  logic              ABORT,
`ifdef PATGEN_LOOP_EN
   input  logic              LOOP,
`endif
   output logic [STAT_W-1:0] STATLATCH,
   output logic [DYN_W-1:0]  DYNLATCH,
   output logic              BUSY,
   output logic              DONE,
   output logic              SIGNAL_OUT
);

   localparam int unsigned CNT_W = $clog2((STAT_W > DYN_W) ? STAT_W : DYN_W);
   localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(STAT_W - 1);
   localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(DYN_W - 1);

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic              sig_d, done_d;
   logic              loop_en;

   logic              stat_ld, dyn_ld, stat_sh, dyn_sh;
   logic              stat_msb, stat_nxt, dyn_msb, dyn_nxt;
   logic [STAT_W-1:0] stat_din;
   logic [DYN_W-1:0]  dyn_din;

   logic [1:0]        cur_mode;
   logic              last_bit, seg_stat;

`ifdef PATGEN_LOOP_EN
   assign loop_en = LOOP;
`else
   assign loop_en = 1'b0;
`endif

   // LOAD coinciding with an accepted START bypasses the shadows.
   assign stat_din = (state == IDLE && LOAD) ? STAT_IN : STATLATCH;
   assign dyn_din  = (state == IDLE && LOAD) ? DYN_IN  : DYNLATCH;

   assign cur_mode = (state == IDLE) ? MODE : mode_q;
   assign last_bit = (cnt == '0);
   assign seg_stat = (state == SEG0) ? stat_first(mode_q) : !stat_first(mode_q);

   pattern_shifter #(.W(STAT_W)) u_stat (
      .CLK   (CLK),
      .RST_N (RST_N),
      .load  (stat_ld),
      .shift (stat_sh),
      .din   (stat_din),
      .msb   (stat_msb),
      .nxt   (stat_nxt)
   );

   pattern_shifter #(.W(DYN_W)) u_dyn (
      .CLK   (CLK),
      .RST_N (RST_N),
      .load  (dyn_ld),
      .shift (dyn_sh),
      .din   (dyn_din),
      .msb   (dyn_msb),
      .nxt   (dyn_nxt)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         mode_q     <= MODE_STAT;
         SIGNAL_OUT <= 1'b0;
         DONE       <= 1'b0;
         STATLATCH  <= STAT_INIT;
         DYNLATCH   <= DYN_INIT;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         mode_q     <= mode_d;
         SIGNAL_OUT <= sig_d;
         DONE       <= done_d;
         if (LOAD) begin
            STATLATCH <= STAT_IN;
            DYNLATCH  <= DYN_IN;
         end
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (START) state_d = SEG0;
         SEG0: begin
            if (ABORT)
               state_d = IDLE;
            else if (last_bit) begin
               if (two_seg(mode_q)) state_d = SEG1;
               else if (loop_en)    state_d = SEG0;
               else                 state_d = IDLE;
            end
         end
         SEG1: begin
            if (ABORT)
               state_d = IDLE;
            else if (last_bit)
               state_d = loop_en ? SEG0 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // SIGNAL_OUT is registered, so sig_d is the bit to present next cycle.
   always_comb begin
      stat_ld = 1'b0;
      dyn_ld  = 1'b0;
      stat_sh = 1'b0;
      dyn_sh  = 1'b0;
      cnt_d   = cnt;
      mode_d  = mode_q;
      sig_d   = 1'b0;
      done_d  = 1'b0;
      if (state == IDLE) begin
         if (START) begin
            mode_d  = MODE;
            stat_ld = 1'b1;
            dyn_ld  = 1'b1;
            cnt_d   = stat_first(MODE) ? STAT_LAST : DYN_LAST;
            sig_d   = stat_first(MODE) ? stat_din[STAT_W-1] : dyn_din[DYN_W-1];
         end
      end else if (ABORT) begin
         cnt_d = '0;
      end else if (!last_bit) begin
         stat_sh = seg_stat;
         dyn_sh  = !seg_stat;
         cnt_d   = cnt - CNT_W'(1);
         sig_d   = seg_stat ? stat_nxt : dyn_nxt;
      end else if (state == SEG0 && two_seg(mode_q)) begin
         cnt_d = stat_first(mode_q) ? DYN_LAST : STAT_LAST;
         sig_d = stat_first(mode_q) ? dyn_msb : stat_msb;
      end else if (loop_en) begin
         stat_ld = 1'b1;
         dyn_ld  = 1'b1;
         cnt_d   = stat_first(cur_mode) ? STAT_LAST : DYN_LAST;
         sig_d   = stat_first(cur_mode) ? stat_din[STAT_W-1] : dyn_din[DYN_W-1];
      end else begin
         done_d = 1'b1;
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_shift_pattern_gen.sv
// Directed self-checking bench for shift_pattern_gen; covers the loop
// feature as well when built with `PATGEN_LOOP_EN.
module tb_shift_pattern_gen;

   localparam logic [87:0] S_INIT = 88'h123456789ABCDEF1234567;
   localparam logic [15:0] D_INIT = 16'hABCD;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        LOAD = 1'b0;
   logic [87:0] STAT_IN = '0;
   logic [15:0] DYN_IN = '0;
   logic [1:0]  MODE = 2'b00;
   logic        START = 1'b0;
   logic        ABORT = 1'b0;
`ifdef PATGEN_LOOP_EN
   logic        LOOP = 1'b0;
`endif
   logic [87:0] STATLATCH;
   logic [15:0] DYNLATCH;
   logic        BUSY, DONE, SIGNAL_OUT;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   shift_pattern_gen dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .LOAD       (LOAD),
      .STAT_IN    (STAT_IN),
      .DYN_IN     (DYN_IN),
      .MODE       (MODE),
      .START      (START),
      .ABORT      (ABORT),
`ifdef PATGEN_LOOP_EN
      .LOOP       (LOOP),
`endif
      .STATLATCH  (STATLATCH),
      .DYNLATCH   (DYNLATCH),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .SIGNAL_OUT (SIGNAL_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Checks len bits of seq (right-aligned, first bit at seq[len-1]),
   // starting in the cycle after START, then the DONE cycle.
   task automatic expect_stream(input string tag, input logic [103:0] seq, input int unsigned len);
      for (int unsigned k = 0; k < len; k++) begin
         check({tag, " bit"}, 88'(SIGNAL_OUT), 88'(seq[len-1-k]));
         check({tag, " busy"}, 88'(BUSY), 88'd1);
         check({tag, " done"}, 88'(DONE), 88'd0);
         tick();
      end
      check({tag, " done pulse"}, 88'(DONE), 88'd1);
      check({tag, " busy end"}, 88'(BUSY), 88'd0);
      check({tag, " sig end"}, 88'(SIGNAL_OUT), 88'd0);
   endtask

   task automatic start_mode(input logic [1:0] m);
      MODE = m;
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   initial begin
      logic [103:0] seq;

      // Reset values
      repeat (2) tick();
      check("rst statlatch", STATLATCH, S_INIT);
      check("rst dynlatch", 88'(DYNLATCH), 88'(D_INIT));
      check("rst sig", 88'(SIGNAL_OUT), 88'd0);
      check("rst busy", 88'(BUSY), 88'd0);
      check("rst done", 88'(DONE), 88'd0);
      RST_N = 1'b1;
      tick();

      // MODE 01: ABCD, DONE in cycle 17 only
      start_mode(2'b01);
      seq = 104'(D_INIT);
      expect_stream("m01", seq, 16);
      tick();
      check("m01 done once", 88'(DONE), 88'd0);

      // MODE 11: 16 dynamic then 88 static bits back-to-back
      start_mode(2'b11);
      seq = {D_INIT, S_INIT};
      expect_stream("m11", seq, 104);
      tick();

      // MODE 10 with a MODE change mid-transmission (must be ignored)
      start_mode(2'b10);
      MODE = 2'b01;
      seq = {S_INIT, D_INIT};
      expect_stream("m10", seq, 104);
      tick();

      // LOAD during transmission; restart on the DONE cycle
      MODE = 2'b01;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
         check("ld cur bit", 88'(SIGNAL_OUT), 88'(D_INIT[15-k]));
         if (k == 3) begin
            LOAD = 1'b1;
            STAT_IN = S_INIT;
            DYN_IN = 16'hFFFF;
         end
         if (k == 4) begin
            LOAD = 1'b0;
            check("ld dynlatch", 88'(DYNLATCH), 88'h0FFFF);
         end
         tick();
      end
      check("ld done", 88'(DONE), 88'd1);
      START = 1'b1;
      tick();
      START = 1'b0;
      seq = 104'(16'hFFFF);
      expect_stream("ld next", seq, 16);
      tick();

      // ABORT in cycle 5 of MODE 00; START in cycle 3 ignored
      start_mode(2'b00);
      for (int unsigned k = 1; k <= 5; k++) begin
         check("ab bit", 88'(SIGNAL_OUT), 88'(S_INIT[88-k]));
         check("ab busy", 88'(BUSY), 88'd1);
         START = (k == 3);
         ABORT = (k == 5);
         tick();
      end
      START = 1'b0;
      ABORT = 1'b0;
      check("ab sig", 88'(SIGNAL_OUT), 88'd0);
      check("ab busy off", 88'(BUSY), 88'd0);
      check("ab no done", 88'(DONE), 88'd0);
      tick();
      check("ab no done late", 88'(DONE), 88'd0);
      check("ab idle", 88'(BUSY), 88'd0);

      // ABORT in IDLE has no effect; bypass LOAD+START
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      LOAD = 1'b1;
      DYN_IN = 16'h8001;
      STAT_IN = '1;
      start_mode(2'b01);
      LOAD = 1'b0;
      seq = 104'(16'h8001);
      expect_stream("byp", seq, 16);
      tick();

      // Async reset mid-shift
      start_mode(2'b00);
      repeat (3) tick();
      check("mid sig pre", 88'(SIGNAL_OUT), 88'd1);
      #2 RST_N = 1'b0;
      #1;
      check("mid statlatch", STATLATCH, S_INIT);
      check("mid dynlatch", 88'(DYNLATCH), 88'(D_INIT));
      check("mid sig", 88'(SIGNAL_OUT), 88'd0);
      check("mid busy", 88'(BUSY), 88'd0);
      check("mid done", 88'(DONE), 88'd0);
      tick();
      RST_N = 1'b1;
      tick();

`ifdef PATGEN_LOOP_EN
      // Loop: two back-to-back passes, drop LOOP during the third
      LOOP = 1'b1;
      start_mode(2'b01);
      for (int unsigned k = 0; k < 48; k++) begin
         check("loop bit", 88'(SIGNAL_OUT), 88'(D_INIT[15-(k%16)]));
         check("loop busy", 88'(BUSY), 88'd1);
         check("loop done", 88'(DONE), 88'd0);
         if (k == 36) LOOP = 1'b0;
         tick();
      end
      check("loop done end", 88'(DONE), 88'd1);
      check("loop busy end", 88'(BUSY), 88'd0);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish within bound");
      $fatal(1);
   end

endmodule
